// File: rtl/fht_ram_sequencer_if.sv
// rtl/fht_ram_sequencer_if.sv - frame control and RAM addressing bundle of the FHT RAM sequencer
// slave is the sequencer itself; master is whatever starts frames and consumes the strobes.
interface fht_ram_sequencer_if #(
    parameter int A_BIT   = 8,
    parameter int STG_BIT = 3
);
    logic               iSTART;
    logic               iVALID;
    logic               oREADY;
    logic [A_BIT-1:0]   oADDR_RD;
    logic [A_BIT-1:0]   oADDR_WR;
    logic [3:0]         oWE;
    logic               oRD_EN;
    logic [STG_BIT-1:0] oSTAGE;
    logic               oBF_VALID;
    logic               oOUT_VALID;
    logic [1:0]         oOUT_SEL;
    logic               oBUSY;
    logic               oDONE;

    modport slave (
        input  iSTART, iVALID,
        output oREADY, oADDR_RD, oADDR_WR, oWE, oRD_EN, oSTAGE,
               oBF_VALID, oOUT_VALID, oOUT_SEL, oBUSY, oDONE
    );

    modport master (
        output iSTART, iVALID,
        input  oREADY, oADDR_RD, oADDR_WR, oWE, oRD_EN, oSTAGE,
               oBF_VALID, oOUT_VALID, oOUT_SEL, oBUSY, oDONE
    );
endinterface

// File: rtl/fht_ram_sequencer.sv
// rtl/fht_ram_sequencer.sv - load / radix-4 compute / unload address sequencer for a 4-bank FHT RAM
// One shared counter serves every phase; compute writes replay the read address BF_LAT cycles later.
module fht_ram_sequencer #(
    parameter int A_BIT   = 8,
    parameter int STAGES  = 4,
    parameter int STG_BIT = 3,
    parameter int BF_LAT  = 4,
    parameter int RD_LAT  = 2
) (
    input logic               iCLK,
    input logic               iRESET,
    fht_ram_sequencer_if.slave bus
);
    localparam int CW = A_BIT + 2;
    localparam logic [CW-1:0]      FRAME_LAST = CW'((4 << A_BIT) - 1);
    localparam logic [CW-1:0]      COMP_LAST  = CW'((1 << A_BIT) - 1);
    localparam logic [CW-1:0]      DRAIN_LAST = CW'(BF_LAT - 1);
    localparam logic [CW-1:0]      FLUSH_LAST = CW'(RD_LAT - 1);
    localparam logic [STG_BIT-1:0] STAGE_LAST = STG_BIT'(STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_DRAIN,
        S_UNLOAD,
        S_FLUSH
    } state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [STG_BIT-1:0] stage_q;
    logic [BF_LAT-1:0]  bf_vld_q;
    logic [A_BIT-1:0]   bf_addr_q [BF_LAT];
    logic [RD_LAT-1:0]  out_vld_q;
    logic [1:0]         out_sel_q [RD_LAT];

    logic               accept;
    logic               comp_rd;
    logic               unl_rd;
    logic [A_BIT-1:0]   c_addr;
    logic [A_BIT-1:0]   rot_addr;
    logic               bf_vld_out;

    assign accept     = (state_q == S_LOAD) && bus.iVALID;
    assign comp_rd    = (state_q == S_COMP);
    assign unl_rd     = (state_q == S_UNLOAD);
    assign c_addr     = cnt_q[A_BIT-1:0];
    assign bf_vld_out = bf_vld_q[BF_LAT-1];

    // Stage k visits digit position k: rotate the counter left by 2k bits.
    always_comb begin
        rot_addr = c_addr;
        for (int k = 1; k < STAGES; k++) begin
            if (stage_q == STG_BIT'(k)) begin
                rot_addr = (c_addr << (2 * k)) | (c_addr >> (A_BIT - 2 * k));
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            stage_q   <= '0;
            bf_vld_q  <= '0;
            out_vld_q <= '0;
            for (int k = 0; k < BF_LAT; k++) bf_addr_q[k] <= '0;
            for (int k = 0; k < RD_LAT; k++) out_sel_q[k] <= '0;
        end else begin
            bf_vld_q[0]  <= comp_rd;
            bf_addr_q[0] <= rot_addr;
            for (int k = 1; k < BF_LAT; k++) begin
                bf_vld_q[k]  <= bf_vld_q[k-1];
                bf_addr_q[k] <= bf_addr_q[k-1];
            end
            out_vld_q[0] <= unl_rd;
            out_sel_q[0] <= cnt_q[1:0];
            for (int k = 1; k < RD_LAT; k++) begin
                out_vld_q[k] <= out_vld_q[k-1];
                out_sel_q[k] <= out_sel_q[k-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.iSTART) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        stage_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (cnt_q == FRAME_LAST) begin
                            state_q <= S_COMP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_COMP: begin
                    if (cnt_q == COMP_LAST) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The final DRAIN cycle carries the stage's last write-back.
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q <= '0;
                        if (stage_q == STAGE_LAST) begin
                            state_q <= S_UNLOAD;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= S_COMP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (cnt_q == FRAME_LAST) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.oREADY     = (state_q == S_LOAD);
    assign bus.oRD_EN     = comp_rd | unl_rd;
    assign bus.oADDR_RD   = comp_rd ? rot_addr :
                            unl_rd  ? cnt_q[A_BIT+1:2] : '0;
    assign bus.oWE        = accept ? (4'b0001 << cnt_q[1:0]) : {4{bf_vld_out}};
    assign bus.oADDR_WR   = accept     ? cnt_q[A_BIT+1:2] :
                            bf_vld_out ? bf_addr_q[BF_LAT-1] : '0;
    assign bus.oBF_VALID  = bf_vld_out;
    assign bus.oSTAGE     = stage_q;
    assign bus.oOUT_VALID = out_vld_q[RD_LAT-1];
    assign bus.oOUT_SEL   = out_vld_q[RD_LAT-1] ? out_sel_q[RD_LAT-1] : 2'b00;
    assign bus.oBUSY      = (state_q != S_IDLE);
    assign bus.oDONE      = (state_q == S_FLUSH) && (cnt_q == FLUSH_LAST);
endmodule

// File: tb/tb_fht_ram_sequencer.sv
// tb/tb_fht_ram_sequencer.sv - self-checking bench for fht_ram_sequencer
// Frames are traced per cycle and compared against a frame schedule computed from the phase rules.
module tb_fht_ram_sequencer;
    localparam int A_BIT   = 8;
    localparam int STAGES  = 4;
    localparam int STG_BIT = 3;
    localparam int BF_LAT  = 4;
    localparam int RD_LAT  = 2;
    localparam int N       = 1 << A_BIT;
    localparam int SPAN    = N + BF_LAT;
    localparam int BUDGET  = 20000;

    typedef struct {
        bit ready, vin, rd_en, bf_valid, out_valid, busy, done;
        int addr_rd, addr_wr, we, stage, out_sel;
    } snap_t;

    typedef struct {
        string name;
        int    kind;
        int    stage;
        int    idx;
        int    exp_a;
        int    exp_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fht_ram_sequencer_if #(.A_BIT(A_BIT), .STG_BIT(STG_BIT)) bus ();

    fht_ram_sequencer #(
        .A_BIT(A_BIT), .STAGES(STAGES), .STG_BIT(STG_BIT), .BF_LAT(BF_LAT), .RD_LAT(RD_LAT)
    ) dut (
        .iCLK  (clk),
        .iRESET(rst),
        .bus   (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    bit    log_en   = 0;
    bit    done_seen = 0;
    snap_t trace[$];
    vec_t  vecs[10];

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int rotl(int c, int s);
        return ((c << s) | (c >> (A_BIT - s))) & (N - 1);
    endfunction

    function automatic longint outs();
        return 64'({bus.oREADY, bus.oADDR_RD, bus.oADDR_WR, bus.oWE, bus.oRD_EN, bus.oSTAGE,
                    bus.oBF_VALID, bus.oOUT_VALID, bus.oOUT_SEL, bus.oBUSY, bus.oDONE});
    endfunction

    function automatic snap_t snap();
        snap_t s;
        s.ready = bus.oREADY;       s.vin = bus.iVALID;         s.rd_en = bus.oRD_EN;
        s.bf_valid = bus.oBF_VALID; s.out_valid = bus.oOUT_VALID;
        s.busy = bus.oBUSY;         s.done = bus.oDONE;
        s.addr_rd = int'(bus.oADDR_RD); s.addr_wr = int'(bus.oADDR_WR); s.we = int'(bus.oWE);
        s.stage = int'(bus.oSTAGE);     s.out_sel = int'(bus.oOUT_SEL);
        return s;
    endfunction

    always @(negedge clk) begin
        if (log_en) begin
            trace.push_back(snap());
            if (bus.oDONE) done_seen = 1;
        end
    end

    task automatic run_frame(input bit rnd);
        int post;
        trace.delete();
        done_seen = 0;
        post = 0;
        @(posedge clk); #1;
        log_en = 1;
        bus.iSTART = 1'b1;
        bus.iVALID = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk); #1;
            bus.iSTART = (k == 40 || k == 2500);
            bus.iVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_seen) begin
                post++;
                if (post >= 3) break;
            end
        end
        log_en = 0;
        bus.iSTART = 1'b0;
        bus.iVALID = 1'b0;
        check("frame_done_seen", done_seen, 1);
    endtask

    task automatic analyze(input bit use_table);
        int sz, n, ld_bad, last_acc, comp_start, unl_start, done_t;
        int rd_bad, wr_bad, out_bad, ctl_bad, t, cnt;
        int accept_cyc[4*N];
        int comp_cyc[STAGES][N];
        int unl_cyc[4*N];
        int first_rd[STAGES];
        int exp_rd[], exp_wr[], exp_out[], exp_stg[];

        sz = trace.size();
        check("trace_nonempty", sz > 2, 1);
        if (sz <= 2) return;
        check("load_entry_ready", trace[1].ready, 1);

        n = 0; ld_bad = 0; last_acc = -1;
        for (int i = 0; i < sz; i++) begin
            if (trace[i].ready) begin
                if (trace[i].vin) begin
                    if (trace[i].we != (1 << (n % 4)) || trace[i].addr_wr != n / 4) ld_bad++;
                    if (n < 4 * N) accept_cyc[n] = i;
                    last_acc = i;
                    n++;
                end else if (trace[i].we != 0) begin
                    ld_bad++;
                end
                if (trace[i].stage != 0) ld_bad++;
            end
        end
        check("load_accepts", n, 4 * N);
        check("load_writes", ld_bad, 0);
        if (n != 4 * N) return;

        comp_start = last_acc + 1;
        unl_start  = comp_start + STAGES * SPAN;
        done_t     = unl_start + 4 * N - 1 + RD_LAT;
        check("frame_length", sz >= done_t + 2, 1);
        if (sz < done_t + 2) return;
        check("ready_drop_after_last", trace[comp_start].ready, 0);

        exp_rd = new[sz]; exp_wr = new[sz]; exp_out = new[sz]; exp_stg = new[sz];
        for (int i = 0; i < sz; i++) begin
            exp_rd[i] = -1; exp_wr[i] = -1; exp_out[i] = -1; exp_stg[i] = -1;
        end
        for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < N; c++) begin
                t = comp_start + s * SPAN + c;
                comp_cyc[s][c] = t;
                exp_rd[t]  = rotl(c, 2 * s);
                exp_stg[t] = s;
                exp_wr[t + BF_LAT] = exp_rd[t];
            end
        end
        for (int m = 0; m < 4 * N; m++) begin
            t = unl_start + m;
            unl_cyc[m] = t;
            exp_rd[t] = m / 4;
            exp_out[t + RD_LAT] = m % 4;
        end

        rd_bad = 0; wr_bad = 0; out_bad = 0; ctl_bad = 0;
        for (int i = 0; i < sz; i++) begin
            if (trace[i].rd_en != (exp_rd[i] >= 0) ||
                trace[i].addr_rd != (exp_rd[i] >= 0 ? exp_rd[i] : 0)) rd_bad++;
            if (exp_stg[i] >= 0 && trace[i].stage != exp_stg[i]) rd_bad++;
            if (!trace[i].ready) begin
                if (trace[i].we != (exp_wr[i] >= 0 ? 15 : 0) ||
                    trace[i].addr_wr != (exp_wr[i] >= 0 ? exp_wr[i] : 0) ||
                    trace[i].bf_valid != (exp_wr[i] >= 0)) wr_bad++;
            end
            if (trace[i].out_valid != (exp_out[i] >= 0) ||
                trace[i].out_sel != (exp_out[i] >= 0 ? exp_out[i] : 0)) out_bad++;
            if (trace[i].done != (i == done_t) ||
                trace[i].busy != (i >= 1 && i <= done_t) ||
                trace[i].ready != (i >= 1 && i <= last_acc)) ctl_bad++;
        end
        check("read_schedule", rd_bad, 0);
        check("writeback_schedule", wr_bad, 0);
        check("unload_stream", out_bad, 0);
        check("done_busy_ready", ctl_bad, 0);

        for (int s = 0; s < STAGES; s++) begin
            first_rd[s] = -1;
            for (int i = comp_start; i < sz; i++) begin
                if (trace[i].rd_en && trace[i].stage == s) begin
                    first_rd[s] = i;
                    break;
                end
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            check($sformatf("stage%0d_span", s), first_rd[s] - first_rd[s-1], SPAN);
            cnt = 0;
            for (int i = 0; i < sz && i < first_rd[s]; i++) if (trace[i].we == 15) cnt++;
            check($sformatf("hazard_before_stage%0d", s), cnt, s * N);
        end

        if (use_table) begin
            for (int v = 0; v < 10; v++) begin
                case (vecs[v].kind)
                    0: begin
                        t = accept_cyc[vecs[v].idx];
                        check({vecs[v].name, "_addr_wr"}, trace[t].addr_wr, vecs[v].exp_a);
                        check({vecs[v].name, "_we"}, trace[t].we, vecs[v].exp_b);
                    end
                    1: begin
                        t = comp_cyc[vecs[v].stage][vecs[v].idx];
                        check({vecs[v].name, "_addr_rd"}, trace[t].addr_rd, vecs[v].exp_a);
                        check({vecs[v].name, "_addr_wr_later"}, trace[t + BF_LAT].addr_wr, vecs[v].exp_b);
                    end
                    default: begin
                        t = unl_cyc[vecs[v].idx];
                        check({vecs[v].name, "_addr_rd"}, trace[t].addr_rd, vecs[v].exp_a);
                        check({vecs[v].name, "_out_sel"}, trace[t + RD_LAT].out_sel, vecs[v].exp_b);
                    end
                endcase
            end
        end
    endtask

    initial begin
        bit found;
        int quiet;
        vecs[0] = '{"ld_n5",       0, 0, 5,    1,    2};
        vecs[1] = '{"ld_n1023",    0, 0, 1023, 255,  8};
        vecs[2] = '{"cp_s1_c01",   1, 1, 1,    'h04, 'h04};
        vecs[3] = '{"cp_s3_c01",   1, 3, 1,    'h40, 'h40};
        vecs[4] = '{"cp_s2_c81",   1, 2, 'h81, 'h18, 'h18};
        vecs[5] = '{"cp_s0_cab",   1, 0, 'hAB, 'hAB, 'hAB};
        vecs[6] = '{"cp_s1_cc3",   1, 1, 'hC3, 'h0F, 'h0F};
        vecs[7] = '{"un_m2",       2, 0, 2,    0,    2};
        vecs[8] = '{"un_m5",       2, 0, 5,    1,    1};
        vecs[9] = '{"un_m1023",    2, 0, 1023, 255,  3};

        bus.iSTART = 1'b0;
        bus.iVALID = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_outputs_zero", outs(), 0);
        end

        run_frame(1'b1);
        analyze(1'b1);

        bus.iVALID = 1'b1;
        @(posedge clk); #1 bus.iSTART = 1'b1;
        @(posedge clk); #1 bus.iSTART = 1'b0;
        found = 0;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (bus.oRD_EN && bus.oSTAGE == 2) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_stage2", found, 1);
        if (found) begin
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                bus.iSTART = (k == 50);
            end
            bus.iSTART = 1'b0;
            check("abort_c100_addr_rd", bus.oADDR_RD, rotl(100, 4));
            check("abort_c100_stage", bus.oSTAGE, 2);
            rst = 1'b1;
            @(negedge clk);
            check("abort_outputs_zero", outs(), 0);
            rst = 1'b0;
            bus.iVALID = 1'b0;
            quiet = 0;
            repeat (10) begin
                @(negedge clk);
                if (outs() != 0) quiet++;
            end
            check("abort_quiet_after", quiet, 0);
        end

        run_frame(1'b1);
        analyze(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
